// File: rtl/video_timing_ctrl.sv
// Pixel-clock raster sequencer: TMDS control streams, pixel coordinates, frame markers,
// and a vertical-blanking-only access grant for the game-board update logic.
module video_timing_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int GUARD_LINES = 2
) (
    input  logic        pixclk,
    input  logic        rst_n,
    output logic        VDE,
    output logic [1:0]  CD,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_start,
    output logic [15:0] frame_cnt,
    input  logic        upd_req,
    input  logic        upd_done,
    output logic        upd_gnt,
    output logic        upd_abort
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] WIN_END = 10'(V_TOTAL - GUARD_LINES);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        GRANT,
        WAIT_LOW
    } state_t;

    // h/v hold the position that the output registers will show after the next edge.
    logic [9:0] h, v;
    logic [9:0] h_nxt, v_nxt;
    logic       h_wrap, v_wrap;
    logic       hs_on, vs_on;
    logic       win_close, win_ok;
    state_t     state;

    assign h_wrap = (h == H_LAST);
    assign v_wrap = (v == V_LAST);
    assign h_nxt  = h_wrap ? 10'd0 : h + 10'd1;
    assign v_nxt  = h_wrap ? (v_wrap ? 10'd0 : v + 10'd1) : v;

    assign hs_on = (h >= HS_BEG) && (h < HS_END);
    assign vs_on = (v >= VS_BEG) && (v < VS_END);

    // Closing edge: the output is about to show the first guard line.
    assign win_close = (h == 10'd0) && (v == WIN_END);
    // Granting on the closing edge would leave upd_gnt high outside the window.
    assign win_ok    = (pix_y >= V_ACT) && (pix_y < WIN_END) && !win_close;

    always_ff @(posedge pixclk) begin
        if (!rst_n) begin
            h           <= '0;
            v           <= '0;
            VDE         <= 1'b0;
            CD          <= {~VS_POL, ~HS_POL};
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            h           <= h_nxt;
            v           <= v_nxt;
            VDE         <= (h < H_ACT) && (v < V_ACT);
            CD          <= {vs_on ? VS_POL : ~VS_POL, hs_on ? HS_POL : ~HS_POL};
            pix_x       <= h;
            pix_y       <= v;
            frame_start <= (h == 10'd0) && (v == 10'd0);
            if (h_wrap && v_wrap)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    always_ff @(posedge pixclk) begin
        if (!rst_n) begin
            state     <= IDLE;
            upd_gnt   <= 1'b0;
            upd_abort <= 1'b0;
        end else begin
            upd_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (upd_req) begin
                        if (win_ok) begin
                            state   <= GRANT;
                            upd_gnt <= 1'b1;
                        end else begin
                            state <= PEND;
                        end
                    end
                end
                PEND: begin
                    if (win_ok) begin
                        state   <= GRANT;
                        upd_gnt <= 1'b1;
                    end
                end
                GRANT: begin
                    // A normal release takes priority over the window closing.
                    if (upd_done || !upd_req) begin
                        state   <= WAIT_LOW;
                        upd_gnt <= 1'b0;
                    end else if (win_close) begin
                        state     <= WAIT_LOW;
                        upd_gnt   <= 1'b0;
                        upd_abort <= 1'b1;
                    end
                end
                WAIT_LOW: begin
                    if (!upd_req)
                        state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    upd_gnt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Scoreboard bench for video_timing_ctrl on a reduced raster: the driver predicts each output
// cycle from raster arithmetic and a grant model, the monitor compares after every edge.
module tb_video_timing_ctrl;

    localparam int HA = 16, HF = 2, HSW = 4, HB = 2;
    localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
    localparam int G  = 2;
    localparam bit HSP = 1'b1, VSP = 1'b1;
    localparam int HT = HA + HF + HSW + HB;   // 24
    localparam int VT = VA + VF + VSW + VB;   // 7
    localparam int FT = HT * VT;              // 168

    typedef struct packed {
        logic        vde;
        logic [1:0]  cd;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        fs;
        logic [15:0] fcnt;
        logic        gnt;
        logic        abort;
    } obs_t;

    logic        pixclk;
    logic        rst_n;
    logic        VDE;
    logic [1:0]  CD;
    logic [9:0]  pix_x, pix_y;
    logic        frame_start;
    logic [15:0] frame_cnt;
    logic        upd_req, upd_done;
    logic        upd_gnt, upd_abort;

    video_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(HSP), .VS_POL(VSP), .GUARD_LINES(G)
    ) dut (
        .pixclk(pixclk), .rst_n(rst_n),
        .VDE(VDE), .CD(CD), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .frame_cnt(frame_cnt),
        .upd_req(upd_req), .upd_done(upd_done),
        .upd_gnt(upd_gnt), .upd_abort(upd_abort)
    );

    initial pixclk = 1'b1;
    always #5 pixclk = ~pixclk;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: cycles since reset release, last shown position, grant bookkeeping.
    int m_k = 0;
    int m_px = 0, m_py = 0;
    bit m_granted = 0, m_waiting = 0, m_blocked = 0;

    task automatic drive(input bit rn, input bit rq, input bit dn);
        obs_t e;
        int   idx, x, y;
        bit   closing, win_ok, ab, hs_on, vs_on;
        @(negedge pixclk);
        rst_n    = rn;
        upd_req  = rq;
        upd_done = dn;
        if (!rn) begin
            e = '{vde: 1'b0, cd: {!VSP, !HSP}, x: 10'd0, y: 10'd0, fs: 1'b0,
                  fcnt: 16'd0, gnt: 1'b0, abort: 1'b0};
            m_k = 0; m_px = 0; m_py = 0;
            m_granted = 0; m_waiting = 0; m_blocked = 0;
        end else begin
            idx   = m_k % FT;
            x     = idx % HT;
            y     = idx / HT;
            hs_on = (x >= HA + HF) && (x < HA + HF + HSW);
            vs_on = (y >= VA + VF) && (y < VA + VF + VSW);
            closing = (x == 0) && (y == VT - G);
            win_ok  = (m_py >= VA) && (m_py < VT - G) && !closing;
            ab = 0;
            if (m_granted) begin
                if (dn || !rq) begin
                    m_granted = 0; m_blocked = 1;
                end else if (closing) begin
                    m_granted = 0; m_blocked = 1; ab = 1;
                end
            end else if (m_blocked) begin
                if (!rq) m_blocked = 0;
            end else if (m_waiting) begin
                if (win_ok) begin
                    m_granted = 1; m_waiting = 0;
                end
            end else if (rq) begin
                if (win_ok) m_granted = 1;
                else m_waiting = 1;
            end
            e.vde   = (x < HA) && (y < VA);
            e.cd    = {vs_on ? VSP : !VSP, hs_on ? HSP : !HSP};
            e.x     = 10'(x);
            e.y     = 10'(y);
            e.fs    = (idx == 0);
            e.fcnt  = 16'((m_k + 1) / FT);
            e.gnt   = m_granted;
            e.abort = ab;
            m_px = x; m_py = y;
            m_k++;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: one comparison per output cycle, plus the grant/active-video exclusion.
    initial begin
        obs_t e, got;
        int   cyc;
        cyc = 0;
        forever begin
            @(posedge pixclk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = '{vde: VDE, cd: CD, x: pix_x, y: pix_y, fs: frame_start,
                        fcnt: frame_cnt, gnt: upd_gnt, abort: upd_abort};
                n_checks++;
                if (got !== e) begin
                    n_errors++;
                    $display("FAIL outputs cycle %0d: got vde=%b cd=%b x=%0d y=%0d fs=%b fcnt=%0d gnt=%b abort=%b, expected vde=%b cd=%b x=%0d y=%0d fs=%b fcnt=%0d gnt=%b abort=%b",
                             cyc, got.vde, got.cd, got.x, got.y, got.fs, got.fcnt, got.gnt, got.abort,
                             e.vde, e.cd, e.x, e.y, e.fs, e.fcnt, e.gnt, e.abort);
                end
                n_checks++;
                if (upd_gnt === 1'b1 && VDE === 1'b1) begin
                    n_errors++;
                    $display("FAIL gnt_during_vde cycle %0d: got gnt=1 vde=1, required not both", cyc);
                end
                cyc++;
            end
        end
    end

    initial begin
        bit r, d, rn;
        rst_n = 1'b0; upd_req = 1'b0; upd_done = 1'b0;

        repeat (3) drive(0, 0, 0);
        repeat (2 * FT) drive(1, 0, 0);

        // Request mid-frame, completion inside the window.
        for (int i = 0; i < 2 * FT; i++) begin
            d = m_granted && (m_py == VA) && (m_px == 10);
            drive(1, 1, d);
            if (d) break;
        end
        repeat (10) drive(1, 0, 0);

        // Held request: window close aborts, re-grant only after req drops.
        repeat (2 * FT) drive(1, 1, 0);
        repeat (3) drive(1, 0, 0);
        repeat (FT) drive(1, 1, 0);
        repeat (5) drive(1, 0, 0);

        // Done on the last window pixel: release, no abort.
        for (int i = 0; i < 2 * FT; i++) begin
            d = m_granted && (m_px == HT - 1) && (m_py == VT - G - 1);
            drive(1, 1, d);
            if (d) break;
        end
        repeat (5) drive(1, 0, 0);

        // Reset in the middle of a grant.
        for (int i = 0; i < 3 * FT; i++) begin
            if (m_granted && (m_py == VA) && (m_px == 5)) break;
            drive(1, 1, 0);
        end
        repeat (3) drive(0, 1, 0);
        repeat (2 * FT) drive(1, 1, 0);
        repeat (5) drive(1, 0, 0);

        // Randomized traffic with occasional resets.
        r = 0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 15) == 0) r = !r;
            d  = ($urandom_range(0, 7) == 0);
            if (m_granted && (m_px == HT - 1) && (m_py == VT - G - 1) && ($urandom_range(0, 1) == 1))
                d = 1;
            rn = ($urandom_range(0, 999) != 0);
            drive(rn, r, d);
        end

        @(posedge pixclk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/video_timing_ctrl.md
# video_timing_ctrl

Pixel-clock timing sequencer for the HDMI output path. It generates the `VDE` and `CD[1:0]` control streams consumed by the three TMDS encoders, along with registered pixel coordinates and frame markers for the pixel source. It also schedules access to the game-board state: the Tetris game logic requests an update window, and the block grants it only during vertical blanking, so the image never tears.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 0, hsync active level
- `VS_POL`, 0, vsync active level
- `GUARD_LINES`, 2, blank lines before frame end in which no grant is held

Ports:
- `pixclk` in 1: pixel clock, sole clock
- `rst_n` in 1: reset, synchronous, active-low
- `VDE` out 1: video data enable to encoders
- `CD` out 2: `{vsync, hsync}` to encoders
- `pix_x` out 10: column of current output pixel
- `pix_y` out 10: line of current output pixel
- `frame_start` out 1: 1-cycle pulse at position (0,0)
- `frame_cnt` out 16: completed-frame counter
- `upd_req` in 1: game logic requests board-update window
- `upd_done` in 1: game logic finished update (1-cycle pulse)
- `upd_gnt` out 1: update window granted
- `upd_abort` out 1: 1-cycle pulse, grant revoked by window close

## Operation
- `H_TOTAL` = H_ACTIVE+H_FP+H_SYNC+H_BP (800). `V_TOTAL` is the analogous vertical sum (525).
- Internal counters: `h` runs 0..H_TOTAL-1 and wraps to 0. `v` increments on each `h` wrap, runs 0..V_TOTAL-1, and wraps to 0.
- All outputs are registered and describe the same position (h,v), so there is no skew between them.
  - `VDE` = (h<H_ACTIVE && v<V_ACTIVE).
  - hsync is active for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync is active for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (490..491).
  - Active means the level given by `HS_POL`/`VS_POL`; otherwise the output is the inverse level.
  - `pix_x`=h and `pix_y`=v at all times, including blanking.
- `frame_start` is 1 at (0,0) only.
- `frame_cnt` increments by 1 on the cycle that (V_TOTAL-1, H_TOTAL-1) is output, and wraps from 0xFFFF to 0.
- Update window: positions with V_ACTIVE ≤ v < V_TOTAL-GUARD_LINES (lines 480..522).
- Grant FSM:
  - IDLE: `upd_req`=1 → PEND.
  - PEND: the output position is inside the window → GRANT; `upd_gnt`=1 from the next cycle.
  - GRANT:
    - `upd_done`=1 or `upd_req`=0 → WAIT_LOW, and `upd_gnt` drops the next cycle.
    - Output position reaches (h=0, v=V_TOTAL-GUARD_LINES) while still granted → `upd_gnt` drops and `upd_abort`=1, both for the next cycle only; then → WAIT_LOW.
    - `upd_done` and window close in the same cycle: done wins, no abort.
  - WAIT_LOW: `upd_req`=0 → IDLE. A new request is therefore served no earlier than the next window.
  - `upd_done` outside GRANT is ignored.
  - A request arriving inside the window is granted in the same window.

## Timing
- Reset values while `rst_n`=0 at a clock edge:
  - `VDE`=0, `CD`={~VS_POL,~HS_POL}, `pix_x`=0, `pix_y`=0
  - `frame_start`=0, `frame_cnt`=0, `upd_gnt`=0, `upd_abort`=0
  - FSM=IDLE, h=v=0
- First edge with `rst_n`=1: outputs show (0,0), with `VDE`=1 and `frame_start`=1 (default parameters). Each later edge advances one pixel.
- Reset asserted mid-frame or mid-grant: every output takes its reset value at that edge. `upd_gnt` falls with no abort pulse.
- Grant latency: 1 cycle from the window being reached (or `upd_req` rising inside the window) to `upd_gnt`=1.
- Release latency: 1 cycle from `upd_done` to `upd_gnt`=0.
- `upd_gnt` is never 1 while `VDE`=1.

## Test plan
- Reset release, run 2 frames → `frame_start` pulses 420000 cycles apart. Per line: `VDE`=1 for 640 cycles, hsync low for 96 cycles starting at h=656. Vsync low exactly on v=490..491. `frame_cnt`=2.
- `upd_req` raised at (100,200), `upd_done` at (10,481) → `upd_gnt` rises when output position is (1,480) and falls at (11,481). No abort. `VDE`=0 throughout the grant.
- `upd_req` held with no done → grant from v=480 until output position (0,523). `upd_abort` pulse at (0,523). Next grant occurs only after `upd_req` drops and re-rises.
- `upd_done` coincident with window close (at position (H_TOTAL-1,522)) → `upd_gnt` drops, `upd_abort` stays 0.
- `rst_n` low for 3 cycles during a grant at v=500 → all outputs at reset values. Restart at (0,0). `upd_gnt` stays 0 until the next window with `upd_req`=1.
- Parameter override with HS_POL=1, VS_POL=1, H_ACTIVE=16, H_FP=2, H_SYNC=4, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 → H_TOTAL=24 and V_TOTAL=7. Sync pulses are high-active at h=18..21 and v=5. `frame_start` period is 168 cycles.
